// File: rtl/data_mem_responder_if.sv
// M-stage data memory bus between the pipeline (master) and the memory responder (slave).
`timescale 1ns/1ps
interface data_mem_responder_if;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        stall;
   logic        err;

   modport master (
      output mem_read, mem_write, addr, write_data,
      input  read_data, stall, err
   );

   modport slave (
      input  mem_read, mem_write, addr, write_data,
      output read_data, stall, err
   );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder: freezes the pipeline for LATENCY+1 cycles per access,
// then releases it for one cycle with the load result or the error flag updated.
//
// state | meaning
// IDLE  | no access in flight; a request raises stall and is latched
// BUSY  | wait cycles counting down; stall held high
// DONE  | result visible, stall low for one cycle; stores commit on exit
`timescale 1ns/1ps
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   data_mem_responder_if.slave  bus
);
   localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        r_state;
   logic [3:0]    r_cnt;
   logic [31:0]   r_addr;
   logic [31:0]   r_wdata;
   logic          r_is_rd;
   logic          r_is_wr;
   logic          r_dual;
   logic [31:0]   r_rdata;
   logic          r_err;
   logic [31:0]   r_mem [DEPTH_WORDS];

   logic          w_req;
   logic          w_bad;
   logic [AW-1:0] w_idx;

   assign w_req = bus.mem_read | bus.mem_write;
   assign w_idx = r_addr[AW+1:2];
   // Misaligned and out-of-range share one path; range uses the full word index, not the truncated one.
   assign w_bad = (r_addr[1:0] != 2'b00) || (r_addr[31:2] >= 30'(DEPTH_WORDS));

   assign bus.stall     = reset & (((r_state == IDLE) & w_req) | (r_state == BUSY));
   assign bus.read_data = r_rdata;
   assign bus.err       = r_err;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_is_rd <= 1'b0;
         r_is_wr <= 1'b0;
         r_dual  <= 1'b0;
         r_rdata <= 32'd0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  r_addr  <= bus.addr;
                  r_wdata <= bus.write_data;
                  r_is_rd <= bus.mem_read & ~bus.mem_write;
                  r_is_wr <= bus.mem_write;
                  r_dual  <= bus.mem_read & bus.mem_write;
                  r_cnt   <= CNT_LOAD;
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               if (r_cnt == 4'd0) begin
                  r_state <= DONE;
                  if (w_bad || r_dual) r_err <= 1'b1;
                  if (r_is_rd) r_rdata <= w_bad ? 32'd0 : r_mem[w_idx];
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   // Store commits on the DONE exit edge so a reset landing in DONE still aborts it.
   always_ff @(posedge clk) begin
      if ((r_state == DONE) && r_is_wr && !w_bad) r_mem[w_idx] <= r_wdata;
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against an array-based reference of the access rules;
// also times single reads on LATENCY=1 and LATENCY=15 instances.
`timescale 1ns/1ps
module tb_data_mem_responder;
   localparam int LAT = 2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   logic [31:0] m_mem [256];
   logic [31:0] m_rdata = 32'd0;
   logic        m_err = 1'b0;

   data_mem_responder_if bus ();
   data_mem_responder_if b1 ();
   data_mem_responder_if b15 ();

   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) u_dut   (.clk(clk), .reset(reset), .bus(bus));
   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1))   u_dut1  (.clk(clk), .reset(reset), .bus(b1));
   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(15))  u_dut15 (.clk(clk), .reset(reset), .bus(b15));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1 of a cycle in which the responder is idle; returns at posedge+1 of the
   // cycle after DONE, with the request held across the DONE edge like a stalled pipeline would.
   task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input string tag);
      int          n;
      logic        bad;
      logic [29:0] w;
      w   = a[31:2];
      bad = (a[1:0] != 2'b00) || (w >= 30'd256);
      if (bad || (rd && wr)) m_err = 1'b1;
      if (wr && !bad) m_mem[w[7:0]] = d;
      if (rd && !wr) m_rdata = bad ? 32'd0 : m_mem[w[7:0]];

      bus.mem_read   = rd;
      bus.mem_write  = wr;
      bus.addr       = a;
      bus.write_data = d;
      n = 0;
      @(negedge clk);
      while (bus.stall && n < 40) begin
         n++;
         @(negedge clk);
      end
      check({tag, "_stall"}, 32'(n), 32'(LAT + 1));
      check({tag, "_rdata"}, bus.read_data, m_rdata);
      check({tag, "_err"}, {31'd0, bus.err}, {31'd0, m_err});
      @(posedge clk);
      #1;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
   endtask

   task automatic idle(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int          n;
      int          kind;
      int          sel;
      logic [31:0] a;

      bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.addr = 32'd0; bus.write_data = 32'd0;
      b1.mem_read  = 1'b0; b1.mem_write  = 1'b0; b1.addr  = 32'd0; b1.write_data  = 32'd0;
      b15.mem_read = 1'b0; b15.mem_write = 1'b0; b15.addr = 32'd0; b15.write_data = 32'd0;

      #1;
      bus.mem_read = 1'b1;
      #1;
      check("rst_stall", {31'd0, bus.stall}, 32'd0);
      check("rst_rdata", bus.read_data, 32'd0);
      check("rst_err", {31'd0, bus.err}, 32'd0);
      bus.mem_read = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;

      for (int i = 0; i < 256; i++) access(1'b0, 1'b1, 32'(i * 4), $urandom, "init");

      access(1'b0, 1'b1, 32'h10, 32'h3F800000, "st_10");
      access(1'b1, 1'b0, 32'h10, 32'd0, "ld_10");
      access(1'b1, 1'b0, 32'h20, 32'd0, "b2b_ld_20");

      for (int i = 0; i < 150; i++) begin
         a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
         if ($urandom_range(0, 1) == 0) access(1'b1, 1'b0, a, 32'd0, "rndA_ld");
         else                           access(1'b0, 1'b1, a, $urandom, "rndA_st");
         idle($urandom_range(0, 2));
      end

      access(1'b1, 1'b0, 32'h13, 32'd0, "misal_ld");
      access(1'b1, 1'b0, 32'h20, 32'd0, "ld_after_err");
      access(1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, "oor_st");
      access(1'b1, 1'b0, 32'h0, 32'd0, "oor_w0");
      access(1'b1, 1'b0, 32'h3FC, 32'd0, "oor_w255");
      access(1'b1, 1'b1, 32'h14, 32'h0BADF00D, "dual_rw");
      access(1'b1, 1'b0, 32'h14, 32'd0, "dual_ld");

      access(1'b0, 1'b1, 32'h4, 32'h12345678, "pre_st");
      access(1'b1, 1'b0, 32'h4, 32'd0, "pre_ld");
      bus.mem_write  = 1'b1;
      bus.addr       = 32'h8;
      bus.write_data = 32'hDEADBEEF;
      @(negedge clk);
      @(negedge clk);
      check("busy_stall", {31'd0, bus.stall}, 32'd1);
      reset = 1'b0;
      m_err = 1'b0;
      m_rdata = 32'd0;
      #1;
      check("abort_stall", {31'd0, bus.stall}, 32'd0);
      check("abort_rdata", bus.read_data, 32'd0);
      check("abort_err", {31'd0, bus.err}, 32'd0);
      bus.mem_write = 1'b0;
      bus.mem_read  = 1'b1;
      #1;
      check("rst_req_stall", {31'd0, bus.stall}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      access(1'b1, 1'b0, 32'h8, 32'd0, "post_rst_ld8");

      for (int i = 0; i < 150; i++) begin
         kind = $urandom_range(0, 2);
         sel  = $urandom_range(0, 9);
         if (sel < 7)       a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
         else if (sel == 7) a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
         else if (sel == 8) a = {20'd0, 10'($urandom_range(256, 1023)), 2'b00};
         else               a = $urandom;
         access(kind != 1, kind != 0, a, $urandom, "rndB");
         idle($urandom_range(0, 2));
      end

      b1.mem_read = 1'b1;
      n = 0;
      @(negedge clk);
      while (b1.stall && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("lat1_stall", 32'(n), 32'd2);
      @(posedge clk);
      #1;
      b1.mem_read = 1'b0;

      b15.mem_read = 1'b1;
      n = 0;
      @(negedge clk);
      while (b15.stall && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("lat15_stall", 32'(n), 32'd16);
      check("lat15_err", {31'd0, b15.err}, 32'd0);
      @(posedge clk);
      #1;
      b15.mem_read = 1'b0;

      idle(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit words in the data array.
REQ-002 SHALL have parameter LATENCY, default 2: wait cycles per access, legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port mem_read, input, 1 bit: M-stage load request.
REQ-006 SHALL have port mem_write, input, 1 bit: M-stage store request.
REQ-007 SHALL have port addr, input, 32 bits: byte address (M-stage ALU/FPU result).
REQ-008 SHALL have port write_data, input, 32 bits: store data (int or float bit pattern).
REQ-009 SHALL have port read_data, output, 32 bits: registered load data.
REQ-010 SHALL have port stall, output, 1 bit: high means freeze the pipeline.
REQ-011 SHALL have port err, output, 1 bit: sticky access-error flag.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, BUSY and DONE.
REQ-013 In IDLE with mem_read or mem_write high, SHALL latch addr, write_data and the request type, load a 4-bit counter with LATENCY-1, and go to BUSY.
REQ-014 SHALL drive stall combinationally high in IDLE whenever a request is present, so the requesting instruction is held in M from the first cycle.
REQ-015 SHALL hold stall high for the whole of BUSY.
REQ-016 In BUSY, SHALL decrement the counter each cycle and go to DONE in the cycle after the counter reaches 0.
REQ-017 In DONE, a write SHALL update the array word at latched addr[log2(DEPTH_WORDS)+1:2].
REQ-018 In DONE, a read SHALL load read_data with that array word on the same clock edge.
REQ-019 In DONE, SHALL drive stall low for exactly one cycle and then go to IDLE unconditionally.
REQ-020 Total stall cycles per access SHALL equal LATENCY+1, giving an access-to-release latency of LATENCY+2 cycles.
REQ-021 Requests present in DONE SHALL be ignored; only requests seen in IDLE are accepted, so a request is never served twice.
REQ-022 read_data SHALL hold its last value until the next completed read; writes SHALL NOT change it.
REQ-023 Misaligned access (latched addr[1:0] != 0) SHALL go through the full FSM timing, perform no array write, return read_data = 0, and set err.
REQ-024 Out-of-range access (word index >= DEPTH_WORDS) SHALL behave exactly like a misaligned access.
REQ-025 mem_read and mem_write both high SHALL perform the write only and set err.
REQ-026 err SHALL be sticky; only reset clears it.
REQ-027 The data array SHALL have no reset; its contents survive reset.

Reset
REQ-028 reset low SHALL immediately force the FSM to IDLE, the counter to 0, read_data to 0x00000000 and err to 0, independent of clk.
REQ-029 While reset is low, stall SHALL be 0 and no array write SHALL occur.
REQ-030 A reset asserted mid-access (BUSY or DONE) SHALL abort the access with no array write.
REQ-031 The first request after reset release SHALL be accepted on the first rising edge with reset high.

Verification
REQ-032 Store then load, LATENCY=2: write 0x3F800000 to addr 0x10, then read 0x10 -> stall high for 3 cycles per access, read_data = 0x3F800000 in the cycle stall drops, err = 0.
REQ-033 Back-to-back accesses: read of 0x20 in the cycle after DONE -> accepted from IDLE with no gap beyond one stall-low cycle, and the prior write is not repeated.
REQ-034 Misaligned read of 0x13 -> 3 stall cycles, read_data = 0, err = 1; a later aligned read leaves err = 1.
REQ-035 Out-of-range write to addr 0x400 (DEPTH_WORDS=256) -> no word modified (check words 0 and 255), err = 1.
REQ-036 Reset pulse in the middle of BUSY during a write of 0xDEADBEEF to 0x8 -> stall = 0 and read_data = 0 immediately, word 0x8 unchanged, next read of 0x8 returns the old value.
REQ-037 LATENCY=1 and LATENCY=15 builds: a single read -> stall high for exactly 2 and 16 cycles respectively.
